mmu_mapper: RTL and testbench

Parametrised page mapper that translates CPU virtual addresses into physical addresses. It uses a table of page-frame registers, per-page write-protect/valid attributes and a sticky fault status. An identity-initialisation sweep engine can rebuild the table from software. The block sits between the CPU bus and the physical memory decoder, and replaces the fixed 16×8 mapper used in earlier machines.

---
 rtl/mmu_pkg.sv | 33 +++
 rtl/mmu_mapper_if.sv | 21 ++
 rtl/mmu_sweep.sv | 71 +++++++
 rtl/mmu_mapper.sv | 116 +++++++++++
 tb/tb_mmu_mapper.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the page mapper: register map, attribute bits,
// sweep FSM states and the reset-frame rule.
package mmu_pkg;

  // Register group, selected by cpuaddr[PAGE_BITS+1:PAGE_BITS]
  localparam logic [1:0] REG_FRAME = 2'b00;
  localparam logic [1:0] REG_ATTR  = 2'b01;
  localparam logic [1:0] REG_SYS   = 2'b10;

  // Sub-addresses inside the system group (index field)
  localparam int REG_CTRL  = 0;
  localparam int REG_FSTAT = 1;

  localparam int ATTR_WP    = 0;
  localparam int ATTR_VALID = 1;

  // Sticky flag position in the fault status register
  localparam int FSTAT_FLAG = 7;

  typedef enum logic {SW_IDLE, SW_SWEEP} sweep_state_t;

  // Low pages map to themselves; the top reset_high pages map to the top
  // of frame space so the boot ROM/IO area is reachable out of reset.
  function automatic int unsigned reset_frame(int unsigned i, int unsigned npages,
                                              int unsigned frame_width,
                                              int unsigned reset_high);
    int unsigned r;
    if (i < npages - reset_high) r = i;
    else r = (32'd1 << frame_width) - npages + i;
    return r;
  endfunction

endpackage

// File: rtl/mmu_mapper_if.sv
// CPU-side bus of the page mapper: translated access plus register port.
interface mmu_mapper_if #(
  parameter int VA_WIDTH   = 16,
  parameter int PA_WIDTH   = 20,
  parameter int DATA_WIDTH = 8
);
  logic [VA_WIDTH-1:0]   cpuaddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rw;
  logic                  cs;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rdata;
  logic [PA_WIDTH-1:0]   address;
  logic                  fault;
  logic                  busy;

  modport master (output cpuaddr, wdata, rw, cs, mem_we,
                  input  rdata, address, fault, busy);
  modport slave  (input  cpuaddr, wdata, rw, cs, mem_we,
                  output rdata, address, fault, busy);
endinterface

// File: rtl/mmu_sweep.sv
// Identity-initialisation sweep: rewrites every table entry with its reset
// value, one entry per cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SW_IDLE  | table owned by the register port; waiting for a start write
// SW_SWEEP | writing entry idx each cycle; register-port table writes lost
module mmu_sweep
  import mmu_pkg::*;
#(
  parameter int PAGE_BITS   = 4,
  parameter int FRAME_WIDTH = 8,
  parameter int RESET_HIGH  = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   wr_en,
  output logic [PAGE_BITS-1:0]   wr_idx,
  output logic [FRAME_WIDTH-1:0] wr_frame,
  output logic [1:0]             wr_attr
);
  localparam int NPAGES = 2 ** PAGE_BITS;

  sweep_state_t         state, state_nxt;
  logic [PAGE_BITS-1:0] idx, idx_nxt;

  // State and index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SW_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state, index advance and table write strobe
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    case (state)
      SW_IDLE: begin
        if (start) begin
          state_nxt = SW_SWEEP;
          idx_nxt   = '0;
        end
      end
      SW_SWEEP: begin
        wr_en   = 1'b1;
        idx_nxt = idx + PAGE_BITS'(1);
        if (idx == PAGE_BITS'(NPAGES - 1)) state_nxt = SW_IDLE;
      end
      default: state_nxt = SW_IDLE;
    endcase
  end

  // Reset-value data for the entry being written
  always_comb begin
    wr_attr             = '0;
    wr_attr[ATTR_VALID] = 1'b1;
    wr_frame = FRAME_WIDTH'(reset_frame(32'(idx), NPAGES, FRAME_WIDTH, RESET_HIGH));
  end

  assign busy   = (state == SW_SWEEP);
  assign wr_idx = idx;

endmodule

// File: rtl/mmu_mapper.sv
// Page mapper: translates CPU virtual addresses through a table of page
// frames, raises write-protect/invalid faults and records the first one.
module mmu_mapper
  import mmu_pkg::*;
#(
  parameter int VA_WIDTH   = 16,
  parameter int PAGE_BITS  = 4,
  parameter int PA_WIDTH   = 20,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_HIGH = 5
) (
  input logic         clk,
  input logic         reset_n,
  mmu_mapper_if.slave bus
);
  localparam int NPAGES      = 2 ** PAGE_BITS;
  localparam int OFFS_WIDTH  = VA_WIDTH - PAGE_BITS;
  localparam int FRAME_WIDTH = PA_WIDTH - OFFS_WIDTH;

  logic [FRAME_WIDTH-1:0] frame [NPAGES];
  logic [1:0]             attr  [NPAGES];

  logic [PAGE_BITS-1:0]   page, ridx, fstat_page, sw_idx;
  logic [1:0]             sel, sw_attr;
  logic                   reg_wr, reg_rd, start, fstat_clr, fstat_flag;
  logic                   access, sw_busy, sw_wr_en;
  logic [FRAME_WIDTH-1:0] sw_frame;
  logic [DATA_WIDTH-1:0]  rd_mux;

  assign page   = bus.cpuaddr[VA_WIDTH-1 -: PAGE_BITS];
  assign sel    = bus.cpuaddr[PAGE_BITS+1 -: 2];
  assign ridx   = bus.cpuaddr[PAGE_BITS-1:0];
  assign reg_wr = bus.cs && !bus.rw;
  assign reg_rd = bus.cs && bus.rw;

  assign start     = reg_wr && (sel == REG_SYS) && (ridx == PAGE_BITS'(REG_CTRL)) && bus.wdata[0];
  assign fstat_clr = reg_wr && (sel == REG_SYS) && (ridx == PAGE_BITS'(REG_FSTAT));

  // A register-port cycle is not a memory access unless the CPU also writes
  assign access    = bus.mem_we || !bus.cs;
  assign bus.fault = access && (!attr[page][ATTR_VALID] || (bus.mem_we && attr[page][ATTR_WP]));

  assign bus.address = {frame[page], bus.cpuaddr[OFFS_WIDTH-1:0]};
  assign bus.busy    = sw_busy;

  mmu_sweep #(
    .PAGE_BITS  (PAGE_BITS),
    .FRAME_WIDTH(FRAME_WIDTH),
    .RESET_HIGH (RESET_HIGH)
  ) u_sweep (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (sw_busy),
    .wr_en   (sw_wr_en),
    .wr_idx  (sw_idx),
    .wr_frame(sw_frame),
    .wr_attr (sw_attr)
  );

  // Page table: sweep owns it while busy, otherwise the register port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPAGES; i++) begin
        frame[i] <= FRAME_WIDTH'(reset_frame(i, NPAGES, FRAME_WIDTH, RESET_HIGH));
        attr[i]  <= 2'b10;
      end
    end else if (sw_wr_en) begin
      frame[sw_idx] <= sw_frame;
      attr[sw_idx]  <= sw_attr;
    end else if (reg_wr && sel == REG_FRAME) begin
      frame[ridx] <= bus.wdata[FRAME_WIDTH-1:0];
    end else if (reg_wr && sel == REG_ATTR) begin
      attr[ridx] <= {bus.wdata[ATTR_VALID], bus.wdata[ATTR_WP]};
    end
  end

  // Sticky fault status; a fault in the clearing cycle wins over the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fstat_flag <= 1'b0;
      fstat_page <= '0;
    end else if (bus.fault && (!fstat_flag || fstat_clr)) begin
      fstat_flag <= 1'b1;
      fstat_page <= page;
    end else if (fstat_clr) begin
      fstat_flag <= 1'b0;
      fstat_page <= '0;
    end
  end

  // Register read mux; unmapped bits and addresses read zero
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_FRAME: rd_mux = DATA_WIDTH'(frame[ridx]);
      REG_ATTR:  rd_mux[1:0] = attr[ridx];
      REG_SYS: begin
        if (ridx == PAGE_BITS'(REG_CTRL)) begin
          rd_mux[0] = sw_busy;
        end else if (ridx == PAGE_BITS'(REG_FSTAT)) begin
          rd_mux[FSTAT_FLAG]      = fstat_flag;
          rd_mux[PAGE_BITS-1:0]   = fstat_page;
        end
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, zero on cycles without a read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.rdata <= '0;
    else          bus.rdata <= reg_rd ? rd_mux : '0;
  end

endmodule

// File: tb/tb_mmu_mapper.sv
// Directed bench for mmu_mapper: default build (bus_a) and a
// PAGE_BITS=3 / PA_WIDTH=22 / DATA_WIDTH=16 build (bus_b).
module tb_mmu_mapper;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] q;
  int   n;

  always #5 clk = ~clk;

  mmu_mapper_if #(.VA_WIDTH(16), .PA_WIDTH(20), .DATA_WIDTH(8))  bus_a ();
  mmu_mapper_if #(.VA_WIDTH(16), .PA_WIDTH(22), .DATA_WIDTH(16)) bus_b ();

  mmu_mapper dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  mmu_mapper #(.VA_WIDTH(16), .PAGE_BITS(3), .PA_WIDTH(22), .DATA_WIDTH(16), .RESET_HIGH(5))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.cs = 1'b0; bus_a.rw = 1'b1; bus_a.mem_we = 1'b0; bus_a.cpuaddr = '0; bus_a.wdata = '0;
    bus_b.cs = 1'b0; bus_b.rw = 1'b1; bus_b.mem_we = 1'b0; bus_b.cpuaddr = '0; bus_b.wdata = '0;
  endtask

  task automatic drive(input bit b, input bit rd, input logic [1:0] sel, input logic [3:0] idx,
                       input logic [15:0] data, input bit we);
    if (b) begin
      bus_b.cpuaddr = {11'd0, sel, idx[2:0]};
      bus_b.wdata = data; bus_b.rw = rd; bus_b.cs = 1'b1; bus_b.mem_we = we;
    end else begin
      bus_a.cpuaddr = {10'd0, sel, idx};
      bus_a.wdata = data[7:0]; bus_a.rw = rd; bus_a.cs = 1'b1; bus_a.mem_we = we;
    end
  endtask

  task automatic reg_wr(input bit b, input logic [1:0] sel, input logic [3:0] idx, input logic [15:0] data);
    drive(b, 1'b0, sel, idx, data, 1'b0);
    step();
    idle();
  endtask

  task automatic reg_rd(input bit b, input logic [1:0] sel, input logic [3:0] idx, output logic [15:0] d);
    drive(b, 1'b1, sel, idx, 16'h0, 1'b0);
    step();
    d = b ? bus_b.rdata : {8'd0, bus_a.rdata};
    idle();
  endtask

  task automatic xlate(input bit b, input logic [15:0] va, input logic [31:0] exp, input string tag);
    if (b) bus_b.cpuaddr = va; else bus_a.cpuaddr = va;
    #1;
    chk(tag, b ? 32'(bus_b.address) : 32'(bus_a.address), exp);
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_rdata", 32'(bus_a.rdata), 0);
    xlate(0, 16'hB123, 32'hFB123, "rst_xlate_b");
    xlate(0, 16'hA555, 32'h0A555, "rst_xlate_a");
    xlate(0, 16'hF000, 32'hFF000, "rst_xlate_f");
    @(posedge clk); #1 reset_n = 1'b1;
    xlate(0, 16'h3ABC, 32'h03ABC, "rst_xlate_3");
    chk("rst_fault", 32'(bus_a.fault), 0);
    reg_rd(0, 2'b10, 4'h1, q); chk("rst_fstat", 32'(q), 0);

    // remap and readback
    reg_wr(0, 2'b00, 4'h2, 16'h42);
    reg_rd(0, 2'b00, 4'h2, q); chk("frame2_rd", 32'(q), 32'h42);
    step(); chk("rdata_zero", 32'(bus_a.rdata), 0);
    xlate(0, 16'h2010, 32'h42010, "remap_xlate");

    // write protect and sticky status
    reg_wr(0, 2'b01, 4'h5, 16'h03);
    reg_wr(0, 2'b01, 4'h6, 16'h00);
    reg_rd(0, 2'b01, 4'h5, q); chk("attr5_rd", 32'(q), 32'h03);
    bus_a.cpuaddr = 16'h5000; bus_a.mem_we = 1'b1; #1;
    chk("wp_fault", 32'(bus_a.fault), 1);
    step();
    bus_a.mem_we = 1'b0; #1;
    chk("wp_read_ok", 32'(bus_a.fault), 0);
    bus_a.cpuaddr = 16'h6000; #1;
    chk("inv_fault", 32'(bus_a.fault), 1);
    step(); idle();
    reg_rd(0, 2'b10, 4'h1, q); chk("fstat_85", 32'(q), 32'h85);
    reg_wr(0, 2'b01, 4'h0, 16'h03);
    drive(0, 1'b0, 2'b10, 4'h1, 16'h0, 1'b1); #1;
    chk("clr_fault", 32'(bus_a.fault), 1);
    step(); idle();
    reg_rd(0, 2'b10, 4'h1, q); chk("fstat_clr_new", 32'(q), 32'h80);
    reg_wr(0, 2'b01, 4'h0, 16'h02);
    reg_wr(0, 2'b10, 4'h1, 16'h00);
    reg_rd(0, 2'b10, 4'h1, q); chk("fstat_clear", 32'(q), 0);

    // sweep with ignored writes and ignored restart
    reg_wr(0, 2'b00, 4'h0, 16'h11);
    reg_wr(0, 2'b00, 4'hF, 16'h22);
    xlate(0, 16'hF123, 32'h22123, "mod_xlate_f");
    reg_wr(0, 2'b10, 4'h0, 16'h01);
    n = 0;
    while (bus_a.busy && n < 40) begin
      n++;
      if (n == 3)       drive(0, 1'b0, 2'b00, 4'h0, 16'h77, 1'b0);
      else if (n == 4)  drive(0, 1'b0, 2'b01, 4'h1, 16'h00, 1'b0);
      else if (n == 16) drive(0, 1'b0, 2'b10, 4'h0, 16'h01, 1'b0);
      else idle();
      step();
    end
    idle();
    chk("sweep_len", 32'(n), 16);
    chk("busy_fell", 32'(bus_a.busy), 0);
    step(); chk("no_restart", 32'(bus_a.busy), 0);
    reg_rd(0, 2'b00, 4'h0, q); chk("sw_frame0", 32'(q), 32'h00);
    reg_rd(0, 2'b00, 4'hF, q); chk("sw_frame15", 32'(q), 32'hFF);
    reg_rd(0, 2'b00, 4'h2, q); chk("sw_frame2", 32'(q), 32'h02);
    reg_rd(0, 2'b01, 4'h1, q); chk("sw_attr1", 32'(q), 32'h02);
    reg_rd(0, 2'b01, 4'h5, q); chk("sw_attr5", 32'(q), 32'h02);
    xlate(0, 16'hF123, 32'hFF123, "sw_xlate_f");

    // reset in the middle of a sweep
    reg_wr(0, 2'b00, 4'h0, 16'h33);
    reg_wr(0, 2'b00, 4'h9, 16'h55);
    xlate(0, 16'h9000, 32'h55000, "pre_rst_xlate");
    reg_wr(0, 2'b10, 4'h0, 16'h01);
    repeat (6) step();
    chk("mid_busy", 32'(bus_a.busy), 1);
    reset_n = 1'b0; #1;
    chk("abort_busy", 32'(bus_a.busy), 0);
    xlate(0, 16'h0ABC, 32'h00ABC, "abort_xlate0");
    xlate(0, 16'h9000, 32'h09000, "abort_xlate9");
    @(posedge clk); #1 reset_n = 1'b1;
    reg_rd(0, 2'b00, 4'h9, q); chk("abort_frame9", 32'(q), 32'h09);

    // parameter variant: 9-bit frames, 8 pages
    xlate(1, 16'h6123, 32'h3F6123, "v_xlate3");
    xlate(1, 16'hE000, 32'h3FE000, "v_xlate7");
    reg_wr(1, 2'b00, 4'h1, 16'hFF55);
    reg_rd(1, 2'b00, 4'h1, q); chk("v_trunc", 32'(q), 32'h0155);
    xlate(1, 16'h2000, 32'h2AA000, "v_xlate1");
    reg_rd(1, 2'b00, 4'h7, q); chk("v_frame7", 32'(q), 32'h01FF);
    reg_wr(1, 2'b10, 4'h0, 16'h0001);
    n = 0;
    while (bus_b.busy && n < 40) begin
      n++;
      step();
    end
    chk("v_sweep_len", 32'(n), 8);
    reg_rd(1, 2'b00, 4'h1, q); chk("v_sw_frame1", 32'(q), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
